alu_rr_sequencer: RTL and testbench
===================================

// Module: alu_rr_sequencer
// PURPOSE
// - Shares one 4-bit ALU (add, sub, compare, and) between two requesters using round-robin arbitration.
// - Per op: accepts the command (valid/ready), drives the ALU operands and select from registers, captures the selected result, and returns it on a valid/ready response port tagged with the requester id.
// - Sits between the requesters and the ALU. Only one op is in flight at a time.
// PARAMETERS
// - W        4     operand/result width; must match ALU width
// - RR_INIT  0     requester holding priority after reset (0 or 1)
// PORTS
// - clk          in   1   single clock, rising edge
// - rst_n        in   1   synchronous reset, active-low
// - req0_valid   in   1   requester 0 command valid
// - req0_ready   out  1   requester 0 command accepted this cycle
// - req0_a       in   W   operand A
// - req0_b       in   W   operand B
// - req0_op      in   2   00 ADD, 01 SUB, 10 CMP, 11 AND
// - req1_valid/req1_ready/req1_a/req1_b/req1_op   same as req0, requester 1
// - rsp_valid    out  1   response valid
// - rsp_ready    in   1   response consumer ready
// - rsp_id       out  1   requester that issued the op
// - rsp_result   out  W   selected result
// - rsp_flags    out  4   {carry, gt, eq, lt}
// - alu_a        out  W   registered ALU operand A
// - alu_b        out  W   registered ALU operand B
// - alu_s        out  2   ALU select: 00 park, 01 add/sub, 10 cmp, 11 and
// - alu_sum_add, alu_carry_add, alu_sum_sub, alu_carry_sub, alu_gt, alu_eq, alu_lt, alu_and   in   ALU outputs (sums and and are W bits; the rest are 1 bit)
// BEHAVIOUR
// - Clock and reset: one clock domain. Reset is synchronous, active-low. rst_n low at a rising clk edge forces state IDLE.
// - Reset values: all outputs are 0, including alu_s=00. The priority pointer is loaded with RR_INIT. This applies mid-op; any in-flight op is dropped silently.
// - FSM IDLE -> ISSUE -> RESP -> IDLE.
// - IDLE:
//   - Arbitration is combinational. If only one requester's valid is high, that requester wins.
//   - If both valids are high, the requester the priority pointer names wins.
//   - reqN_ready = (state==IDLE) & grant[N]. The ready signals are never both high.
//   - On handshake: latch a, b, op and id. Load alu_a/alu_b. Load alu_s from op (ADD/SUB->01, CMP->10, AND->11). Go to ISSUE.
//   - The priority pointer moves to the non-winner on every grant.
// - ISSUE (one cycle): the ALU is combinational. At the end of the cycle, capture the result:
//   - ADD: rsp_result=alu_sum_add, carry=alu_carry_add
//   - SUB: rsp_result=alu_sum_sub, carry=alu_carry_sub (carry = no-borrow)
//   - CMP: rsp_result=0, {gt,eq,lt}=ALU flags
//   - AND: rsp_result=alu_and
//   - Flags that do not apply to the op are 0.
//   - Set rsp_valid=1, set alu_s=00 (park), go to RESP.
// - RESP:
//   - rsp_* are held stable while rsp_valid & ~rsp_ready.
//   - On rsp_valid & rsp_ready: clear rsp_valid and go to IDLE.
//   - No command is accepted in RESP, so a new accept happens at the earliest on the cycle after the response handshake.
// - Latency: command handshake at cycle t -> rsp_valid high at t+2. Throughput is one op per 3 cycles with rsp_ready held high.
// - Requester valids and operands may change freely while that requester's ready is low; the block ignores them.
// - alu_a/alu_b keep the last operands while parked. alu_s=00 guarantees the ALU inputs are gated off.
// STRUCTURE
// - Shared package alu_seq_pkg:
//   - op codes OP_ADD/OP_SUB/OP_CMP/OP_AND
//   - ALU select constants SEL_PARK/SEL_ADDSUB/SEL_CMP/SEL_AND
//   - state encoding IDLE/ISSUE/RESP
//   - flag bit indices
// - One sub-module, rr_arb2: two-input round-robin arbiter (valid[1:0], pointer in, grant[1:0] out; combinational). The pointer register lives in the parent.
// TESTING
// - Reset, then req0 ADD a=9 b=8 -> rsp_valid at t+2, id=0, result=1, flags=1000 (carry). alu_s 01 during ISSUE, 00 otherwise.
// - req1 SUB a=5 b=3 -> result=2, flags=1000. SUB a=3 b=5 -> result=E, flags=0000.
// - req0 CMP a=3 b=7 -> result=0, flags=0001. CMP a=6 b=6 -> flags=0010. AND a=C b=A -> result=8, flags=0000.
// - Both valid at the same cycle after reset with RR_INIT=0 -> req0 served first, then req1. Hold both valid for 4 ops -> ids alternate 0,1,0,1.
// - rsp_ready low for 5 cycles in RESP -> rsp_* stable. req0_ready and req1_ready stay 0. The next grant comes 1 cycle after the handshake.
// - rst_n low during ISSUE -> next cycle all outputs 0 and state IDLE. The op is never responded to, and the pointer returns to RR_INIT.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the round-robin ALU sequencer: op codes, ALU select
// values, sequencer states and response flag positions.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_CMP = 2'b10,
    OP_AND = 2'b11
  } aluOp_t;

  typedef enum logic [1:0] {
    SEL_PARK   = 2'b00,
    SEL_ADDSUB = 2'b01,
    SEL_CMP    = 2'b10,
    SEL_AND    = 2'b11
  } aluSel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    RESP  = 2'b10
  } seqState_t;

  localparam int FLAG_CARRY = 3;
  localparam int FLAG_GT    = 2;
  localparam int FLAG_EQ    = 1;
  localparam int FLAG_LT    = 0;

  // ADD and SUB share one ALU select; the sequencer picks the right output later.
  function automatic aluSel_t opToSel(input aluOp_t op);
    case (op)
      OP_ADD, OP_SUB: opToSel = SEL_ADDSUB;
      OP_CMP:         opToSel = SEL_CMP;
      default:        opToSel = SEL_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_rr_sequencer_arb.sv
// Two-input combinational round-robin arbiter; the priority pointer is owned
// by the instantiating block.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant
);

  always_comb begin
    grant = valid;
    if (valid[0] && valid[1]) begin
      grant = ptr ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/alu_rr_sequencer.sv
// Shares one external combinational ALU between two requesters, one op in
// flight at a time, with a round-robin grant and a tagged response port.
module alu_rr_sequencer
  import alu_seq_pkg::*;
#(
  parameter int   W       = 4,
  parameter logic RR_INIT = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [1:0]   req0_op,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic [1:0]   req1_op,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_result,
  output logic [3:0]   rsp_flags,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [1:0]   alu_s,
  input  logic [W-1:0] alu_sum_add,
  input  logic         alu_carry_add,
  input  logic [W-1:0] alu_sum_sub,
  input  logic         alu_carry_sub,
  input  logic         alu_gt,
  input  logic         alu_eq,
  input  logic         alu_lt,
  input  logic [W-1:0] alu_and
);

  seqState_t    state, stateNext;
  logic [1:0]   grant;
  logic         rrPtr;
  logic         accept;
  logic         winId;
  logic [W-1:0] winA, winB;
  aluOp_t       winOp;
  aluOp_t       opReg;
  logic         idReg;
  logic [W-1:0] resultNext;
  logic [3:0]   flagsNext;

  rr_arb2 uArb (
    .valid({req1_valid, req0_valid}),
    .ptr  (rrPtr),
    .grant(grant)
  );

  assign req0_ready = (state == IDLE) & grant[0];
  assign req1_ready = (state == IDLE) & grant[1];
  assign accept     = req0_ready | req1_ready;
  assign winId      = grant[1];
  assign winA       = winId ? req1_a : req0_a;
  assign winB       = winId ? req1_b : req0_b;
  assign winOp      = aluOp_t'(winId ? req1_op : req0_op);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (accept) stateNext = ISSUE;
      ISSUE:   stateNext = RESP;
      RESP:    if (rsp_valid && rsp_ready) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Only the flags meaningful for the latched op survive; the rest read 0.
  always_comb begin
    resultNext = '0;
    flagsNext  = '0;
    case (opReg)
      OP_ADD: begin
        resultNext            = alu_sum_add;
        flagsNext[FLAG_CARRY] = alu_carry_add;
      end
      OP_SUB: begin
        resultNext            = alu_sum_sub;
        flagsNext[FLAG_CARRY] = alu_carry_sub;
      end
      OP_CMP: begin
        flagsNext[FLAG_GT] = alu_gt;
        flagsNext[FLAG_EQ] = alu_eq;
        flagsNext[FLAG_LT] = alu_lt;
      end
      default: resultNext = alu_and;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rrPtr      <= RR_INIT;
      opReg      <= OP_ADD;
      idReg      <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_s      <= SEL_PARK;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
    end else begin
      if (accept) begin
        alu_a <= winA;
        alu_b <= winB;
        alu_s <= opToSel(winOp);
        opReg <= winOp;
        idReg <= winId;
        rrPtr <= ~winId;
      end
      if (state == ISSUE) begin
        rsp_valid  <= 1'b1;
        rsp_id     <= idReg;
        rsp_result <= resultNext;
        rsp_flags  <= flagsNext;
        alu_s      <= SEL_PARK;
      end
      if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// Testbench for alu_rr_sequencer: behavioural ALU, arithmetic reference model,
// expected-response queue and an independent response monitor.
module tb_alu_rr_sequencer;
  import alu_seq_pkg::*;

  localparam int   W       = 4;
  localparam logic RR_INIT = 1'b0;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [1:0]   req0_op = '0, req1_op = '0;
  logic         rsp_valid, rsp_id;
  logic         rsp_ready = 1'b1;
  logic [W-1:0] rsp_result;
  logic [3:0]   rsp_flags;
  logic [W-1:0] alu_a, alu_b;
  logic [1:0]   alu_s;
  logic [W-1:0] alu_sum_add, alu_sum_sub, alu_and;
  logic         alu_carry_add, alu_carry_sub, alu_gt, alu_eq, alu_lt;

  int checks = 0;
  int failures = 0;
  int cycle = 0;

  typedef struct {
    logic       id;
    logic [3:0] result;
    logic [3:0] flags;
    int         acceptCycle;
  } expRsp_t;

  expRsp_t sb[$];
  logic    idLog[$];

  alu_rr_sequencer #(.W(W), .RR_INIT(RR_INIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
    .alu_sum_add(alu_sum_add), .alu_carry_add(alu_carry_add), .alu_sum_sub(alu_sum_sub), .alu_carry_sub(alu_carry_sub),
    .alu_gt(alu_gt), .alu_eq(alu_eq), .alu_lt(alu_lt), .alu_and(alu_and)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // External ALU: outputs are gated off unless the matching select is driven.
  always_comb begin
    alu_sum_add = '0; alu_carry_add = 1'b0; alu_sum_sub = '0; alu_carry_sub = 1'b0;
    alu_gt = 1'b0; alu_eq = 1'b0; alu_lt = 1'b0; alu_and = '0;
    if (alu_s == 2'b01) begin
      {alu_carry_add, alu_sum_add} = {1'b0, alu_a} + {1'b0, alu_b};
      alu_sum_sub   = alu_a - alu_b;
      alu_carry_sub = (alu_a >= alu_b);
    end
    if (alu_s == 2'b10) begin
      alu_gt = (alu_a > alu_b);
      alu_eq = (alu_a == alu_b);
      alu_lt = (alu_a < alu_b);
    end
    if (alu_s == 2'b11) alu_and = alu_a & alu_b;
  end

  function automatic logic [7:0] refOp(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    int ia = int'(a);
    int ib = int'(b);
    logic [3:0] r = 4'h0;
    logic [3:0] f = 4'h0;
    case (op)
      2'b00: begin r = 4'((ia + ib) % 16); f[3] = ((ia + ib) > 15); end
      2'b01: begin r = 4'((ia - ib + 16) % 16); f[3] = (ia >= ib); end
      2'b10: begin f[2] = (ia > ib); f[1] = (ia == ib); f[0] = (ia < ib); end
      default: r = a & b;
    endcase
    return {r, f};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic setReq(input logic id, input logic v, input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    if (id) begin
      req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
    end else begin
      req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
    end
  endtask

  task automatic waitAccept(input logic id, output int n);
    logic got = 1'b0;
    n = 0;
    while (!got && n < 30) begin
      @(negedge clk);
      n++;
      got = id ? req1_ready : req0_ready;
    end
    if (!got) begin
      n = -1;
      checkOutput("acceptTimeout", 32'(id), 32'hFFFF_FFFF);
    end
  endtask

  task automatic applyStimulus(input logic id, input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                               input logic [3:0] expRes, input logic [3:0] expFlags);
    int n;
    int guard = 0;
    setReq(id, 1'b1, a, b, op);
    waitAccept(id, n);
    @(posedge clk); #1;
    setReq(id, 1'b0, a, b, op);
    while (!rsp_valid && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("dirValid", 32'(rsp_valid), 32'd1);
    checkOutput("dirId", 32'(rsp_id), 32'(id));
    checkOutput("dirResult", 32'(rsp_result), 32'(expRes));
    checkOutput("dirFlags", 32'(rsp_flags), 32'(expFlags));
    @(posedge clk); #1;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "Rsp"}, {rsp_valid, rsp_id, rsp_result, rsp_flags}, 32'd0);
    checkOutput({tag, "Alu"}, {alu_a, alu_b, alu_s}, 32'd0);
    checkOutput({tag, "Ready"}, {req0_ready, req1_ready}, 32'd0);
  endtask

  // Reference model: predicts grants from the round-robin rule and queues the
  // arithmetic result of each accepted command.
  initial begin
    logic busy = 1'b0;
    logic lastPtr = RR_INIT;
    int issueCycle = -10;
    logic [1:0] issueSel = 2'b00;
    logic [3:0] issueA = 4'h0, issueB = 4'h0;
    logic expR0, expR1;
    logic [7:0] rr;
    expRsp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        busy = 1'b0;
        lastPtr = RR_INIT;
        issueCycle = -10;
      end else begin
        expR0 = 1'b0;
        expR1 = 1'b0;
        if (!busy) begin
          if (req0_valid && req1_valid) begin
            expR0 = (lastPtr == 1'b0);
            expR1 = (lastPtr == 1'b1);
          end else begin
            expR0 = req0_valid;
            expR1 = req1_valid;
          end
        end
        checkOutput("req0Ready", 32'(req0_ready), 32'(expR0));
        checkOutput("req1Ready", 32'(req1_ready), 32'(expR1));
        if (cycle == issueCycle) begin
          checkOutput("aluSelIssue", 32'(alu_s), 32'(issueSel));
          checkOutput("aluOperands", {alu_a, alu_b}, {issueA, issueB});
        end else begin
          checkOutput("aluSelPark", 32'(alu_s), 32'd0);
        end
        if (expR0 || expR1) begin
          e.id = expR1;
          issueA = expR1 ? req1_a : req0_a;
          issueB = expR1 ? req1_b : req0_b;
          rr = refOp(issueA, issueB, expR1 ? req1_op : req0_op);
          e.result = rr[7:4];
          e.flags = rr[3:0];
          e.acceptCycle = cycle;
          sb.push_back(e);
          case (expR1 ? req1_op : req0_op)
            2'b10:   issueSel = 2'b10;
            2'b11:   issueSel = 2'b11;
            default: issueSel = 2'b01;
          endcase
          issueCycle = cycle + 1;
          lastPtr = ~expR1;
          busy = 1'b1;
        end else if (busy && rsp_valid && rsp_ready) begin
          busy = 1'b0;
        end
      end
    end
  end

  // Response monitor: latency, stall stability, and in-order payload compare.
  initial begin
    logic prevValid = 1'b0;
    logic prevStall = 1'b0;
    logic [9:0] held = '0;
    expRsp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prevValid = 1'b0;
        prevStall = 1'b0;
        continue;
      end
      if (prevStall) begin
        checkOutput("stallHold", {rsp_valid, rsp_id, rsp_result, rsp_flags}, {1'b1, held[8:0]});
      end
      if (rsp_valid && !prevValid) begin
        if (sb.size() == 0) begin
          checkOutput("rspUnexpected", 32'(rsp_valid), 32'd0);
        end else begin
          checkOutput("rspLatency", 32'(cycle), 32'(sb[0].acceptCycle + 2));
        end
      end
      if (rsp_valid && rsp_ready && sb.size() != 0) begin
        e = sb.pop_front();
        checkOutput("rspId", 32'(rsp_id), 32'(e.id));
        checkOutput("rspResult", 32'(rsp_result), 32'(e.result));
        checkOutput("rspFlags", 32'(rsp_flags), 32'(e.flags));
        idLog.push_back(rsp_id);
      end
      prevStall = rsp_valid && !rsp_ready;
      held = {rsp_valid, rsp_id, rsp_result, rsp_flags};
      prevValid = rsp_valid;
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int accepted;
    int guard;
    logic g0, g1;
    logic [3:0] expIds;

    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    applyStimulus(1'b0, 4'h9, 4'h8, 2'b00, 4'h1, 4'b1000);
    applyStimulus(1'b1, 4'h5, 4'h3, 2'b01, 4'h2, 4'b1000);
    applyStimulus(1'b1, 4'h3, 4'h5, 2'b01, 4'hE, 4'b0000);
    applyStimulus(1'b0, 4'h3, 4'h7, 2'b10, 4'h0, 4'b0001);
    applyStimulus(1'b0, 4'h6, 4'h6, 2'b10, 4'h0, 4'b0010);
    applyStimulus(1'b0, 4'hC, 4'hA, 2'b11, 4'h8, 4'b0000);

    // Reset during ISSUE of a req0 op: the op vanishes and priority restarts.
    setReq(1'b0, 1'b1, 4'h9, 4'h7, 2'b00);
    waitAccept(1'b0, n);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checkResetOutputs("midReset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    idLog.delete();
    setReq(1'b0, 1'b1, 4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)), 2'($urandom_range(3, 0)));
    setReq(1'b1, 1'b1, 4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)), 2'($urandom_range(3, 0)));
    accepted = 0;
    guard = 0;
    while (accepted < 4 && guard < 60) begin
      @(negedge clk);
      guard++;
      g0 = req0_ready;
      g1 = req1_ready;
      if (g0 || g1) begin
        accepted++;
        @(posedge clk); #1;
        setReq(g1, 1'b1, 4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)), 2'($urandom_range(3, 0)));
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    guard = 0;
    while (idLog.size() < 4 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("altCount", 32'(idLog.size()), 32'd4);
    expIds = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      if (i < idLog.size()) checkOutput("altId", 32'(idLog[i]), 32'(expIds[i]));
    end
    @(posedge clk); #1;

    // Response stall with both requesters pending.
    rsp_ready = 1'b0;
    setReq(1'b0, 1'b1, 4'h4, 4'h5, 2'b00);
    waitAccept(1'b0, n);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(posedge clk); #1;
    setReq(1'b0, 1'b1, 4'hF, 4'h1, 2'b00);
    setReq(1'b1, 1'b1, 4'h2, 4'h9, 2'b01);
    repeat (5) @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    waitAccept(1'b1, n);
    checkOutput("grantAfterRsp", 32'(n), 32'd2);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    waitAccept(1'b0, n);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    for (int c = 0; c < 400; c++) begin
      setReq(1'b0, ($urandom_range(99, 0) < 60), 4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)), 2'($urandom_range(3, 0)));
      setReq(1'b1, ($urandom_range(99, 0) < 60), 4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)), 2'($urandom_range(3, 0)));
      rsp_ready = ($urandom_range(99, 0) < 70);
      @(posedge clk); #1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("drainEmpty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
